// File: rtl/dircc_application_pkg.sv
// Application-level types shared by the heat-processing node.
package dircc_application_pkg;

    // Per-device state held in the device-state memory.
    typedef struct packed {
        logic [15:0] temperature;
        logic [15:0] iteration;
    } device_state_t;

endpackage

// File: rtl/dircc_types_pkg.sv
// Requester identifiers for the device-state memory arbiter.
package dircc_types_pkg;

    localparam int unsigned DIRCC_NUM_REQ = 3;

    typedef logic [$clog2(DIRCC_NUM_REQ)-1:0] req_id_t;

    localparam req_id_t REQ_RECEIVE = req_id_t'(0);
    localparam req_id_t REQ_COMPUTE = req_id_t'(1);
    localparam req_id_t REQ_SEND    = req_id_t'(2);

endpackage

// File: rtl/dircc_rr_arbiter.sv
// Pointer-based round-robin arbiter. A held lock overrides the search so a
// stalled winner keeps the grant; the pointer only advances on acceptance.
module dircc_rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic               lock_vld,
    input  logic [IDW-1:0]     lock_id,
    input  logic               accept,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDW-1:0]     grant_id,
    output logic               grant_vld
);

    logic [IDW-1:0] ptr;

    // First valid requester at or after the pointer, wrapping; lock wins outright.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        if (lock_vld) begin
            grant_vld = 1'b1;
            grant_id  = lock_id;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!grant_vld && req_valid[(int'(ptr) + k) % NUM_REQ]) begin
                    grant_vld = 1'b1;
                    grant_id  = IDW'((int'(ptr) + k) % NUM_REQ);
                end
            end
        end
        grant = '0;
        if (grant_vld) grant[grant_id] = 1'b1;
    end

    // Move the pointer just past the accepted requester.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (accept) begin
            if (grant_id == IDW'(NUM_REQ - 1)) ptr <= '0;
            else                               ptr <= grant_id + 1'b1;
        end
    end

endmodule

// File: rtl/dircc_state_mem_arbiter.sv
// Shares one single-port device-state memory between NUM_REQ requesters.
// One access per cycle, waitrequest stall with grant lock, read data routed
// back to the originator MEM_READ_LATENCY+1 cycles after acceptance.
module dircc_state_mem_arbiter
    import dircc_application_pkg::*;
#(
    parameter int NUM_REQ           = 3,
    parameter int ADDRESS_MEM_WIDTH = 32,
    parameter int MEM_READ_LATENCY  = 1
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [NUM_REQ-1:0]                        req_valid,
    input  logic [NUM_REQ-1:0]                        req_write,
    input  logic [NUM_REQ-1:0][ADDRESS_MEM_WIDTH-1:0] req_address,
    input  device_state_t [NUM_REQ-1:0]               req_writedata,
    output logic [NUM_REQ-1:0]                        req_ready,
    output logic [NUM_REQ-1:0]                        rsp_valid,
    output device_state_t                             rsp_data,
    output logic [ADDRESS_MEM_WIDTH-1:0]              mem_address,
    output logic                                      mem_read,
    output logic                                      mem_write,
    output device_state_t                             mem_writedata,
    input  logic                                      mem_waitrequest,
    input  device_state_t                             mem_readdata
);

    localparam int IDW       = $clog2(NUM_REQ);
    localparam int RD_STAGES = MEM_READ_LATENCY - 1;

    logic [NUM_REQ-1:0] arb_grant;
    logic [IDW-1:0]     arb_id;
    logic               arb_vld;
    logic               win_vld;
    logic               accept;
    logic               rd_accept;
    logic               lock_vld;
    logic [IDW-1:0]     lock_id;

    logic [RD_STAGES:0]          vld_pipe;
    logic [RD_STAGES:0][IDW-1:0] id_pipe;

    dircc_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_arb (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .lock_vld  (lock_vld),
        .lock_id   (lock_id),
        .accept    (accept),
        .grant     (arb_grant),
        .grant_id  (arb_id),
        .grant_vld (arb_vld)
    );

    // Nothing is presented to the memory or requesters while reset is held.
    assign win_vld   = arb_vld & ~reset;
    assign accept    = win_vld & ~mem_waitrequest;
    assign rd_accept = accept & ~req_write[arb_id];

    // Drive the memory from the winner; idle bus is all zeros.
    always_comb begin
        mem_address   = '0;
        mem_writedata = '0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        req_ready     = '0;
        if (win_vld) begin
            mem_address   = req_address[arb_id];
            mem_writedata = req_writedata[arb_id];
            mem_read      = ~req_write[arb_id];
            mem_write     = req_write[arb_id];
            if (!mem_waitrequest) req_ready = arb_grant;
        end
    end

    // Hold the stalled winner until the memory takes it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_vld <= 1'b0;
            lock_id  <= '0;
        end else if (win_vld && mem_waitrequest) begin
            lock_vld <= 1'b1;
            lock_id  <= arb_id;
        end else if (accept) begin
            lock_vld <= 1'b0;
        end
    end

    // Track accepted reads and their originator for the memory latency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_pipe <= '0;
            id_pipe  <= '0;
        end else begin
            vld_pipe[0] <= rd_accept;
            id_pipe[0]  <= arb_id;
            for (int i = 1; i <= RD_STAGES; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                id_pipe[i]  <= id_pipe[i-1];
            end
        end
    end

    // Capture returning read data and strobe the owning requester.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid <= '0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= '0;
            if (vld_pipe[RD_STAGES]) begin
                rsp_valid[id_pipe[RD_STAGES]] <= 1'b1;
                rsp_data                      <= mem_readdata;
            end
        end
    end

endmodule

// File: tb/tb_dircc_state_mem_arbiter.sv
// Directed bench: one arbiter with read latency 1 and one with latency 3,
// both fed the same requests and each backed by its own memory model.
module tb_dircc_state_mem_arbiter;
    import dircc_application_pkg::*;
    import dircc_types_pkg::*;

    logic                  clk;
    logic                  reset;
    logic [2:0]            req_valid;
    logic [2:0]            req_write;
    logic [2:0][31:0]      req_address;
    logic [2:0][31:0]      req_writedata;
    logic                  mem_waitrequest;

    logic [2:0]    req_ready1, rsp_valid1, req_ready3, rsp_valid3;
    device_state_t rsp_data1, rsp_data3, mem_writedata1, mem_writedata3;
    device_state_t mem_readdata1, mem_readdata3;
    logic [31:0]   mem_address1, mem_address3;
    logic          mem_read1, mem_write1, mem_read3, mem_write3;

    logic [31:0] mem1 [256];
    logic [31:0] mem3 [256];
    logic [31:0] rd1, p0, p1, p2;

    int nvec = 0;
    int nmis = 0;

    dircc_state_mem_arbiter #(.NUM_REQ(3), .ADDRESS_MEM_WIDTH(32), .MEM_READ_LATENCY(1)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
        .req_address(req_address), .req_writedata(req_writedata),
        .req_ready(req_ready1), .rsp_valid(rsp_valid1), .rsp_data(rsp_data1),
        .mem_address(mem_address1), .mem_read(mem_read1), .mem_write(mem_write1),
        .mem_writedata(mem_writedata1), .mem_waitrequest(mem_waitrequest),
        .mem_readdata(mem_readdata1));

    dircc_state_mem_arbiter #(.NUM_REQ(3), .ADDRESS_MEM_WIDTH(32), .MEM_READ_LATENCY(3)) dut3 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
        .req_address(req_address), .req_writedata(req_writedata),
        .req_ready(req_ready3), .rsp_valid(rsp_valid3), .rsp_data(rsp_data3),
        .mem_address(mem_address3), .mem_read(mem_read3), .mem_write(mem_write3),
        .mem_writedata(mem_writedata3), .mem_waitrequest(mem_waitrequest),
        .mem_readdata(mem_readdata3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory models: location a holds 0xA000+a until written.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) begin
                mem1[i] <= 32'hA000 + i;
                mem3[i] <= 32'hA000 + i;
            end
        end else begin
            if (mem_write1 && !mem_waitrequest) mem1[mem_address1[7:0]] <= mem_writedata1;
            if (mem_write3 && !mem_waitrequest) mem3[mem_address3[7:0]] <= mem_writedata3;
        end
        rd1 <= mem1[mem_address1[7:0]];
        p0  <= mem3[mem_address3[7:0]];
        p1  <= p0;
        p2  <= p1;
    end
    assign mem_readdata1 = rd1;
    assign mem_readdata3 = p2;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic [2:0] v, input logic [2:0] w, input logic wt);
        req_valid       = v;
        req_write       = w;
        mem_waitrequest = wt;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " ready1"},  req_ready1,   3'b000);
        chk({tag, " rsp1"},    rsp_valid1,   3'b000);
        chk({tag, " data1"},   rsp_data1,    32'h0);
        chk({tag, " rd1"},     mem_read1,    1'b0);
        chk({tag, " wr1"},     mem_write1,   1'b0);
        chk({tag, " addr1"},   mem_address1, 32'h0);
        chk({tag, " ready3"},  req_ready3,   3'b000);
        chk({tag, " rsp3"},    rsp_valid3,   3'b000);
        chk({tag, " data3"},   rsp_data3,    32'h0);
        chk({tag, " rd3"},     mem_read3,    1'b0);
    endtask

    logic [2:0]  v6 [8];
    logic [2:0]  r6 [8];
    logic [31:0] d6 [8];

    initial begin
        reset = 1'b1;
        req_address   = '0;
        req_writedata = '0;
        drv(3'b000, 3'b000, 1'b0);
        #3;
        chk_idle("reset");
        tick();
        tick();
        reset = 1'b0;

        // Round robin, continuous reads from all three requesters.
        req_address[0] = 32'h20;
        req_address[1] = 32'h21;
        req_address[2] = 32'h22;
        for (int k = 0; k < 8; k++) begin
            drv((k < 6) ? 3'b111 : 3'b000, 3'b000, 1'b0);
            @(negedge clk);
            if (k < 6) begin
                chk("rr ready", req_ready1, 3'b001 << (k % 3));
                chk("rr addr",  mem_address1, 32'h20 + (k % 3));
                chk("rr read",  mem_read1, 1'b1);
            end else begin
                chk("idle ready", req_ready1, 3'b000);
                chk("idle read",  mem_read1, 1'b0);
            end
            if (k >= 2) begin
                chk("rr rsp",  rsp_valid1, 3'b001 << ((k - 2) % 3));
                chk("rr data", rsp_data1, 32'hA020 + ((k - 2) % 3));
            end
            tick();
        end

        // Stall lock: requester 1 stalled three cycles while requester 0 waits.
        req_address[0] = 32'h30;
        req_address[1] = 32'h31;
        drv(3'b010, 3'b000, 1'b1);
        @(negedge clk);
        chk("lock s0 ready", req_ready1, 3'b000);
        chk("lock s0 addr",  mem_address1, 32'h31);
        chk("lock s0 read",  mem_read1, 1'b1);
        for (int s = 1; s < 3; s++) begin
            tick();
            drv(3'b011, 3'b000, 1'b1);
            @(negedge clk);
            chk("lock hold ready", req_ready1, 3'b000);
            chk("lock hold addr",  mem_address1, 32'h31);
        end
        tick();
        drv(3'b011, 3'b000, 1'b0);
        @(negedge clk);
        chk("lock accept ready", req_ready1, 3'b010);
        chk("lock accept addr",  mem_address1, 32'h31);
        tick();
        drv(3'b001, 3'b000, 1'b0);
        @(negedge clk);
        chk("after lock ready", req_ready1, 3'b001);
        chk("after lock addr",  mem_address1, 32'h30);
        tick();
        drv(3'b000, 3'b000, 1'b0);
        @(negedge clk);
        chk("lock rsp1", rsp_valid1, 3'b010);
        chk("lock data1", rsp_data1, 32'hA031);
        tick();
        @(negedge clk);
        chk("lock rsp0", rsp_valid1, 3'b001);
        chk("lock data0", rsp_data1, 32'hA030);

        // Write then read of the same address.
        tick();
        req_address[1]   = 32'h10;
        req_writedata[1] = 32'h5A;
        drv(3'b010, 3'b010, 1'b0);
        @(negedge clk);
        chk("wr ready", req_ready1, 3'b010);
        chk("wr strobe", mem_write1, 1'b1);
        chk("wr noread", mem_read1, 1'b0);
        chk("wr addr", mem_address1, 32'h10);
        chk("wr data", mem_writedata1, 32'h5A);
        tick();
        req_address[2] = 32'h10;
        drv(3'b100, 3'b000, 1'b0);
        @(negedge clk);
        chk("rd ready", req_ready1, 3'b100);
        chk("rd strobe", mem_read1, 1'b1);
        chk("rd nowrite", mem_write1, 1'b0);
        tick();
        drv(3'b000, 3'b000, 1'b0);
        @(negedge clk);
        chk("wr no rsp", rsp_valid1, 3'b000);
        tick();
        @(negedge clk);
        chk("raw rsp", rsp_valid1, {REQ_SEND == 2'd2, 2'b00});
        chk("raw data", rsp_data1, 32'h5A);

        // Latency-3 instance: four back-to-back reads, ids 0,1,2,1.
        v6 = '{3'b111, 3'b110, 3'b100, 3'b010, 3'b000, 3'b000, 3'b000, 3'b000};
        r6 = '{3'b001, 3'b010, 3'b100, 3'b010, 3'b000, 3'b000, 3'b000, 3'b000};
        d6 = '{32'h0, 32'h0, 32'h0, 32'h0, 32'hA040, 32'hA041, 32'hA042, 32'hA043};
        req_address[0] = 32'h40;
        req_address[1] = 32'h41;
        req_address[2] = 32'h42;
        for (int s = 0; s < 8; s++) begin
            tick();
            if (s == 3) req_address[1] = 32'h43;
            drv(v6[s], 3'b000, 1'b0);
            @(negedge clk);
            if (s < 4) chk("lat3 ready", req_ready3, r6[s]);
            if (s == 3) chk("lat3 early", rsp_valid3, 3'b000);
            if (s >= 4) begin
                chk("lat3 rsp",  rsp_valid3, r6[s-4]);
                chk("lat3 data", rsp_data3, d6[s]);
            end
        end

        // Reset with two reads in flight.
        tick();
        req_address[0] = 32'h50;
        req_address[1] = 32'h51;
        drv(3'b011, 3'b000, 1'b0);
        @(negedge clk);
        chk("pre-rst ready0", req_ready3, 3'b001);
        tick();
        drv(3'b010, 3'b000, 1'b0);
        @(negedge clk);
        chk("pre-rst ready1", req_ready3, 3'b010);
        tick();
        reset = 1'b1;
        drv(3'b011, 3'b000, 1'b0);
        @(negedge clk);
        chk_idle("midrst");
        tick();
        reset = 1'b0;
        drv(3'b000, 3'b000, 1'b0);
        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            chk("post-rst rsp1", rsp_valid1, 3'b000);
            chk("post-rst rsp3", rsp_valid3, 3'b000);
            tick();
        end
        drv(3'b111, 3'b000, 1'b0);
        @(negedge clk);
        chk("post-rst ptr1", req_ready1, 3'b001 << REQ_RECEIVE);
        chk("post-rst ptr3", req_ready3, 3'b001);
        chk("post-rst addr", mem_address3, 32'h50);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
